food_gen: RTL and testbench



---
 rtl/food_gen.sv | 246 ++++++++++++++++++++++++
 tb/tb_food_gen.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/food_gen.sv
`default_nettype none
// ============================================================================
// Module   : food_gen
// Brief    : Places the snake-game food cell. A free-running LFSR proposes a
//            candidate, off-grid candidates are redrawn, and legal ones are
//            compared against one snake segment per cycle before publishing.
//            Optional macro FOOD_SCAN_FALLBACK_EN: after MAX_TRIES collision
//            rejections the candidate source switches to a linear grid scan.
// Revision : 1.0 - initial release
// ============================================================================
module food_gen #(
    parameter int          GRID_W    = 32,
    parameter int          GRID_H    = 24,
    parameter int          MAX_LEN   = 64,
    parameter int          INIT_X    = 20,
    parameter int          INIT_Y    = 12,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
`ifdef FOOD_SCAN_FALLBACK_EN
    ,
    parameter int          MAX_TRIES = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           game_state,
    input  logic                 get_food,
    input  logic [5:0]           snake_length,
    input  logic [5*MAX_LEN-1:0] snake_x_1dim,
    input  logic [5*MAX_LEN-1:0] snake_y_1dim,
    output logic [4:0]           food_x,
    output logic [4:0]           food_y,
    output logic                 food_valid,
    output logic                 busy
);

    localparam logic [1:0]  c_GS_RUNNING = 2'b00;
    localparam logic [1:0]  c_GS_INITIAL = 2'b10;

    localparam logic [1:0]  c_ST_HOLD    = 2'd0;
    localparam logic [1:0]  c_ST_GEN     = 2'd1;
    localparam logic [1:0]  c_ST_CHECK   = 2'd2;
    localparam logic [1:0]  c_ST_COMMIT  = 2'd3;

    localparam int          c_IDX_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [5:0]  c_GRID_W     = 6'(GRID_W);
    localparam logic [5:0]  c_GRID_H     = 6'(GRID_H);
    localparam logic [4:0]  c_INIT_X     = 5'(INIT_X);
    localparam logic [4:0]  c_INIT_Y     = 5'(INIT_Y);
    localparam logic [31:0] c_MAX_LEN    = 32'(MAX_LEN);

`ifdef FOOD_SCAN_FALLBACK_EN
    localparam int               c_TRY_W     = $clog2(MAX_TRIES + 1);
    localparam logic [c_TRY_W-1:0] c_MAX_TRIES = c_TRY_W'(MAX_TRIES);
    localparam logic [4:0]       c_LAST_X    = 5'(GRID_W - 1);
    localparam logic [4:0]       c_LAST_Y    = 5'(GRID_H - 1);
`endif

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [15:0]        r_lfsr;
    logic [15:0]        w_lfsr_nxt;
    logic               w_lfsr_fb;
    logic [4:0]         r_cx;
    logic [4:0]         r_cy;
    logic [4:0]         w_cx_nxt;
    logic [4:0]         w_cy_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic [4:0]         r_food_x;
    logic [4:0]         r_food_y;
    logic [4:0]         w_food_x_nxt;
    logic [4:0]         w_food_y_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_busy;
    logic               w_busy_nxt;

    logic [31:0]        w_len_raw;
    logic [31:0]        w_len;
    logic               w_len_zero;
    logic               w_last_seg;
    logic [4:0]         w_seg_x;
    logic [4:0]         w_seg_y;
    logic               w_hit;
    logic [4:0]         w_cand_x;
    logic [4:0]         w_cand_y;
    logic               w_cand_ok;

`ifdef FOOD_SCAN_FALLBACK_EN
    logic [c_TRY_W-1:0] r_tries;
    logic [c_TRY_W-1:0] w_tries_nxt;
    logic [4:0]         w_scan_x;
    logic [4:0]         w_scan_y;
`endif

    // Taps 16,14,13,11 in right-shift form; runs in every state
    assign w_lfsr_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_lfsr_nxt = {w_lfsr_fb, r_lfsr[15:1]};

    assign w_cand_x   = r_lfsr[4:0];
    assign w_cand_y   = r_lfsr[9:5];
    assign w_cand_ok  = ({1'b0, w_cand_x} < c_GRID_W) && ({1'b0, w_cand_y} < c_GRID_H);

    assign w_len_raw  = {26'd0, snake_length};
    assign w_len      = (w_len_raw > c_MAX_LEN) ? c_MAX_LEN : w_len_raw;
    assign w_len_zero = (w_len == 32'd0);
    // ">=" rather than "==" so a snake shrinking mid-check still terminates
    assign w_last_seg = ((32'(r_idx) + 32'd1) >= w_len);

    always_comb begin
        w_seg_x = 5'd0;
        w_seg_y = 5'd0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_seg_x = snake_x_1dim[5*i +: 5];
                w_seg_y = snake_y_1dim[5*i +: 5];
            end
        end
    end

    assign w_hit = (w_seg_x == r_cx) && (w_seg_y == r_cy);

`ifdef FOOD_SCAN_FALLBACK_EN
    always_comb begin
        w_scan_x = r_cx + 5'd1;
        w_scan_y = r_cy;
        if (r_cx == c_LAST_X) begin
            w_scan_x = 5'd0;
            w_scan_y = (r_cy == c_LAST_Y) ? 5'd0 : r_cy + 5'd1;
        end
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_cx_nxt     = r_cx;
        w_cy_nxt     = r_cy;
        w_idx_nxt    = r_idx;
        w_food_x_nxt = r_food_x;
        w_food_y_nxt = r_food_y;
        w_valid_nxt  = r_valid;
        w_busy_nxt   = r_busy;
`ifdef FOOD_SCAN_FALLBACK_EN
        w_tries_nxt  = r_tries;
`endif
        if (game_state == c_GS_INITIAL) begin
            w_state_nxt  = c_ST_HOLD;
            w_food_x_nxt = c_INIT_X;
            w_food_y_nxt = c_INIT_Y;
            w_valid_nxt  = 1'b1;
            w_busy_nxt   = 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
            w_tries_nxt  = '0;
`endif
        end else begin
            case (r_state)
                c_ST_HOLD: begin
                    if (get_food && (game_state == c_GS_RUNNING)) begin
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = c_ST_GEN;
                    end
                end
                c_ST_GEN: begin
`ifdef FOOD_SCAN_FALLBACK_EN
                    if (r_tries == c_MAX_TRIES) begin
                        w_cx_nxt    = w_scan_x;
                        w_cy_nxt    = w_scan_y;
                        w_idx_nxt   = '0;
                        w_state_nxt = w_len_zero ? c_ST_COMMIT : c_ST_CHECK;
                    end else
`endif
                    if (w_cand_ok) begin
                        w_cx_nxt    = w_cand_x;
                        w_cy_nxt    = w_cand_y;
                        w_idx_nxt   = '0;
                        w_state_nxt = w_len_zero ? c_ST_COMMIT : c_ST_CHECK;
                    end
                end
                c_ST_CHECK: begin
                    if (w_hit) begin
                        w_state_nxt = c_ST_GEN;
`ifdef FOOD_SCAN_FALLBACK_EN
                        if (r_tries != c_MAX_TRIES) begin
                            w_tries_nxt = r_tries + 1'b1;
                        end
`endif
                    end else if (w_last_seg) begin
                        w_state_nxt = c_ST_COMMIT;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
                c_ST_COMMIT: begin
                    w_food_x_nxt = r_cx;
                    w_food_y_nxt = r_cy;
                    w_valid_nxt  = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = c_ST_HOLD;
`ifdef FOOD_SCAN_FALLBACK_EN
                    w_tries_nxt  = '0;
`endif
                end
                default: w_state_nxt = c_ST_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_ST_HOLD;
            r_lfsr   <= LFSR_SEED;
            r_cx     <= 5'd0;
            r_cy     <= 5'd0;
            r_idx    <= '0;
            r_food_x <= c_INIT_X;
            r_food_y <= c_INIT_Y;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
            r_tries  <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_lfsr   <= w_lfsr_nxt;
            r_cx     <= w_cx_nxt;
            r_cy     <= w_cy_nxt;
            r_idx    <= w_idx_nxt;
            r_food_x <= w_food_x_nxt;
            r_food_y <= w_food_y_nxt;
            r_valid  <= w_valid_nxt;
            r_busy   <= w_busy_nxt;
`ifdef FOOD_SCAN_FALLBACK_EN
            r_tries  <= w_tries_nxt;
`endif
        end
    end

    assign food_x     = r_food_x;
    assign food_y     = r_food_y;
    assign food_valid = r_valid;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_food_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_food_gen
// Brief    : Self-checking bench for food_gen (default build) with a
//            behavioural placement model driven by randomized snakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_food_gen;

    localparam int          c_MAX_LEN = 64;
    localparam logic [15:0] c_SEED    = 16'hACE1;
    localparam logic [1:0]  c_RUN     = 2'b00;
    localparam logic [1:0]  c_DIE     = 2'b01;
    localparam logic [1:0]  c_INIT    = 2'b10;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [1:0]             game_state;
    logic                   get_food;
    logic [5:0]             snake_length;
    logic [5*c_MAX_LEN-1:0] snake_x_1dim;
    logic [5*c_MAX_LEN-1:0] snake_y_1dim;
    logic [4:0]             food_x;
    logic [4:0]             food_y;
    logic                   food_valid;
    logic                   busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_lfsr;
    int          sx [c_MAX_LEN];
    int          sy [c_MAX_LEN];
    int          m_len;

    food_gen dut (
        .clk          (clk),
        .rst          (rst),
        .game_state   (game_state),
        .get_food     (get_food),
        .snake_length (snake_length),
        .snake_x_1dim (snake_x_1dim),
        .snake_y_1dim (snake_y_1dim),
        .food_x       (food_x),
        .food_y       (food_y),
        .food_valid   (food_valid),
        .busy         (busy)
    );

    always #10 clk = ~clk;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= c_SEED;
        else      m_lfsr <= lfsr_step(m_lfsr);
    end

    // Placement rules: off-grid draws cost one cycle, a hit on segment j
    // costs 1 GEN + (j+1) CHECK cycles, success costs GEN + len CHECK + COMMIT.
    function automatic void predict(input logic [15:0] v_gen, output int fx, output int fy, output int n);
        logic [15:0] v;
        int cyc;
        int cx;
        int cy;
        int hit;
        v = v_gen; cyc = 0; fx = -1; fy = -1; n = -1;
        for (int guard = 0; guard < 100000; guard++) begin
            cx = int'(v[4:0]);
            cy = int'(v[9:5]);
            if (cx >= 32 || cy >= 24) begin
                v = lfsr_step(v);
                cyc++;
                continue;
            end
            hit = -1;
            for (int i = 0; i < m_len; i++) begin
                if (sx[i] == cx && sy[i] == cy) begin
                    hit = i;
                    break;
                end
            end
            if (hit < 0) begin
                fx = cx; fy = cy; n = cyc + m_len + 2;
                return;
            end
            for (int k = 0; k < hit + 2; k++) v = lfsr_step(v);
            cyc += hit + 2;
        end
    endfunction

    task automatic apply_snake();
        for (int i = 0; i < c_MAX_LEN; i++) begin
            snake_x_1dim[5*i +: 5] = 5'(sx[i]);
            snake_y_1dim[5*i +: 5] = 5'(sy[i]);
        end
        snake_length = 6'(m_len);
    endtask

    task automatic random_snake(input int len);
        m_len = len;
        for (int i = 0; i < c_MAX_LEN; i++) begin
            sx[i] = int'($urandom_range(0, 31));
            sy[i] = int'($urandom_range(0, 23));
        end
        apply_snake();
    endtask

    // Called at a falling edge in HOLD; returns just after the accepting edge
    task automatic pulse(output int fx, output int fy, output int n, output logic [4:0] ox, output logic [4:0] oy);
        predict(lfsr_step(m_lfsr), fx, fy, n);
        ox = food_x;
        oy = food_y;
        get_food = 1'b1;
        @(negedge clk);
        get_food = 1'b0;
    endtask

    task automatic wait_done(input int start, input logic [4:0] ox, input logic [4:0] oy,
                             output int lat, output bit busy_ok, output bit held);
        lat = start; busy_ok = 1'b1; held = 1'b1;
        while (food_valid !== 1'b1 && lat < 5000) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (food_x !== ox || food_y !== oy) held = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; game_state = c_RUN; get_food = 1'b0;
        for (int i = 0; i < c_MAX_LEN; i++) begin sx[i] = 0; sy[i] = 0; end
        m_len = 0;
        apply_snake();
        repeat (3) @(negedge clk);
        n_tests++;
        if (food_x !== 5'd20 || food_y !== 5'd12) begin
            n_fail++; $display("FAIL reset_food: got (%0d,%0d) expected (20,12)", food_x, food_y);
        end
        n_tests++;
        if (food_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got valid=%b busy=%b expected valid=1 busy=0", food_valid, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (food_valid !== 1'b1 || busy !== 1'b0 || food_x !== 5'd20) begin
            n_fail++; $display("FAIL reset_release_hold: got valid=%b busy=%b x=%0d expected 1 0 20", food_valid, busy, food_x);
        end
    endtask

    task automatic test_basic();
        int fx, fy, n, lat;
        bit bok, held;
        logic [4:0] ox, oy;
        m_len = 3;
        sx[0] = 5; sy[0] = 5; sx[1] = 4; sy[1] = 5; sx[2] = 3; sy[2] = 5;
        apply_snake();
        pulse(fx, fy, n, ox, oy);
        wait_done(0, ox, oy, lat, bok, held);
        n_tests++;
        if (lat !== n) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, n); end
        n_tests++;
        if (food_x !== 5'(fx) || food_y !== 5'(fy)) begin
            n_fail++; $display("FAIL basic_food: got (%0d,%0d) expected (%0d,%0d)", food_x, food_y, fx, fy);
        end
        n_tests++;
        if (!bok || !held) begin n_fail++; $display("FAIL basic_busy_window: got busy_ok=%b held=%b expected 1 1", bok, held); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_collision();
        int fx, fy, n, lat, cx, cy, wait_cnt;
        bit bok, held;
        logic [15:0] v;
        logic [4:0] ox, oy;
        wait_cnt = 0;
        v = lfsr_step(m_lfsr);
        while ((v[9:5] >= 5'd24) && wait_cnt < 200) begin
            @(negedge clk); wait_cnt++; v = lfsr_step(m_lfsr);
        end
        cx = int'(v[4:0]); cy = int'(v[9:5]);
        m_len = 3;
        sx[0] = (cx + 1) % 32; sy[0] = cy;
        sx[1] = (cx + 2) % 32; sy[1] = cy;
        for (int i = 2; i < c_MAX_LEN; i++) begin sx[i] = cx; sy[i] = cy; end
        apply_snake();
        pulse(fx, fy, n, ox, oy);
        wait_done(0, ox, oy, lat, bok, held);
        n_tests++;
        if (lat !== n) begin n_fail++; $display("FAIL collide_latency: got %0d expected %0d", lat, n); end
        n_tests++;
        if (lat < 9) begin n_fail++; $display("FAIL collide_rejected: got latency %0d expected >= 9", lat); end
        n_tests++;
        if (food_x !== 5'(fx) || food_y !== 5'(fy)) begin
            n_fail++; $display("FAIL collide_food: got (%0d,%0d) expected (%0d,%0d)", food_x, food_y, fx, fy);
        end
        n_tests++;
        if (food_x === 5'(cx) && food_y === 5'(cy)) begin
            n_fail++; $display("FAIL collide_on_segment: got (%0d,%0d) expected not (%0d,%0d)", food_x, food_y, cx, cy);
        end
    endtask

    task automatic test_illegal();
        int fx, fy, n, lat, wait_cnt;
        bit bok, held;
        logic [15:0] v;
        logic [4:0] ox, oy;
        m_len = 3;
        sx[0] = 5; sy[0] = 5; sx[1] = 4; sy[1] = 5; sx[2] = 3; sy[2] = 5;
        apply_snake();
        wait_cnt = 0;
        v = lfsr_step(m_lfsr);
        while ((v[9:5] < 5'd24) && wait_cnt < 400) begin
            @(negedge clk); wait_cnt++; v = lfsr_step(m_lfsr);
        end
        n_tests++;
        if (wait_cnt >= 400) begin n_fail++; $display("FAIL illegal_setup: got no off-grid draw in %0d cycles expected one", wait_cnt); end
        pulse(fx, fy, n, ox, oy);
        wait_done(0, ox, oy, lat, bok, held);
        n_tests++;
        if (food_y >= 5'd24) begin n_fail++; $display("FAIL illegal_published: got y=%0d expected < 24", food_y); end
        n_tests++;
        if (lat !== n || food_x !== 5'(fx) || food_y !== 5'(fy)) begin
            n_fail++; $display("FAIL illegal_redraw: got lat=%0d (%0d,%0d) expected lat=%0d (%0d,%0d)", lat, food_x, food_y, n, fx, fy);
        end
    endtask

    task automatic test_back_to_back();
        int fx, fy, n, lat, bad;
        bit bok, held;
        logic [4:0] ox, oy;
        random_snake(8);
        pulse(fx, fy, n, ox, oy);
        @(negedge clk);
        get_food = 1'b1;
        @(negedge clk);
        get_food = 1'b0;
        wait_done(2, ox, oy, lat, bok, held);
        n_tests++;
        if (lat !== n || food_x !== 5'(fx) || food_y !== 5'(fy)) begin
            n_fail++; $display("FAIL b2b_ignored: got lat=%0d (%0d,%0d) expected lat=%0d (%0d,%0d)", lat, food_x, food_y, n, fx, fy);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (food_valid !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL b2b_no_queue: got %0d busy cycles expected 0", bad); end
        pulse(fx, fy, n, ox, oy);
        wait_done(0, ox, oy, lat, bok, held);
        n_tests++;
        if (lat !== n || food_x !== 5'(fx) || food_y !== 5'(fy)) begin
            n_fail++; $display("FAIL b2b_second: got lat=%0d (%0d,%0d) expected lat=%0d (%0d,%0d)", lat, food_x, food_y, n, fx, fy);
        end
    endtask

    task automatic test_die();
        int fx, fy, n, lat, bad;
        bit bok, held;
        logic [4:0] ox, oy;
        random_snake(12);
        ox = food_x; oy = food_y;
        game_state = c_DIE;
        get_food = 1'b1;
        @(negedge clk);
        get_food = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (food_valid !== 1'b1 || busy !== 1'b0 || food_x !== ox || food_y !== oy) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL die_hold_frozen: got %0d changed cycles expected 0", bad); end
        game_state = c_RUN;
        pulse(fx, fy, n, ox, oy);
        game_state = c_DIE;
        wait_done(0, ox, oy, lat, bok, held);
        n_tests++;
        if (lat !== n || food_x !== 5'(fx) || food_y !== 5'(fy)) begin
            n_fail++; $display("FAIL die_finish: got lat=%0d (%0d,%0d) expected lat=%0d (%0d,%0d)", lat, food_x, food_y, n, fx, fy);
        end
        game_state = c_RUN;
    endtask

    task automatic test_initial();
        int fx, fy, n, bad;
        logic [4:0] ox, oy;
        random_snake(30);
        pulse(fx, fy, n, ox, oy);
        repeat (2) @(negedge clk);
        game_state = c_INIT;
        get_food = 1'b1;
        @(negedge clk);
        n_tests++;
        if (food_x !== 5'd20 || food_y !== 5'd12 || food_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL initial_abort: got (%0d,%0d) v=%b b=%b expected (20,12) v=1 b=0", food_x, food_y, food_valid, busy);
        end
        game_state = c_RUN;
        get_food = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (food_valid !== 1'b1 || busy !== 1'b0 || food_x !== 5'd20 || food_y !== 5'd12) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL initial_priority: got %0d non-idle cycles expected 0", bad); end
    endtask

    task automatic test_reset_mid();
        int fx, fy, n, lat;
        bit bok, held;
        logic [4:0] ox, oy;
        random_snake(30);
        pulse(fx, fy, n, ox, oy);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        n_tests++;
        if (food_x !== 5'd20 || food_y !== 5'd12 || food_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got (%0d,%0d) v=%b b=%b expected (20,12) v=1 b=0", food_x, food_y, food_valid, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse(fx, fy, n, ox, oy);
        wait_done(0, ox, oy, lat, bok, held);
        n_tests++;
        if (lat !== n || food_x !== 5'(fx) || food_y !== 5'(fy)) begin
            n_fail++; $display("FAIL reset_reseed: got lat=%0d (%0d,%0d) expected lat=%0d (%0d,%0d)", lat, food_x, food_y, n, fx, fy);
        end
    endtask

    task automatic test_random();
        int fx, fy, n, lat, on_snake;
        bit bok, held;
        logic [4:0] ox, oy;
        for (int it = 0; it < 250; it++) begin
            random_snake((it == 0) ? 0 : (it == 1) ? 63 : int'($urandom_range(0, 63)));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            pulse(fx, fy, n, ox, oy);
            wait_done(0, ox, oy, lat, bok, held);
            n_tests++;
            if (lat !== n) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, lat, n); end
            n_tests++;
            if (food_x !== 5'(fx) || food_y !== 5'(fy)) begin
                n_fail++; $display("FAIL rand_food[%0d]: got (%0d,%0d) expected (%0d,%0d)", it, food_x, food_y, fx, fy);
            end
            on_snake = 0;
            for (int i = 0; i < m_len; i++) begin
                if (food_x === 5'(sx[i]) && food_y === 5'(sy[i])) on_snake++;
            end
            n_tests++;
            if (on_snake != 0) begin n_fail++; $display("FAIL rand_free[%0d]: got %0d segment hits expected 0", it, on_snake); end
            n_tests++;
            if (!bok || !held || busy !== 1'b0) begin
                n_fail++; $display("FAIL rand_flags[%0d]: got busy_ok=%b held=%b busy=%b expected 1 1 0", it, bok, held, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_collision();
        test_illegal();
        test_back_to_back();
        test_die();
        test_initial();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
